// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared widths, idle values and strobe levels for the CPU buses.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int MAIN_WIDTH = 8;

    localparam logic [ADDR_WIDTH-1:0] ADDR_BUS_IDLE = '1;
    localparam logic [MAIN_WIDTH-1:0] MAIN_BUS_IDLE = '1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Control strobes throughout the datapath are active-low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/addr_register_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_register_if
// Description : Bus/strobe bundle of the address register. Macro
//               ADDR_REG_ADDR_LOAD_EN adds the load_addr strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface addr_register_if
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
);
    logic [WIDTH-1:0] addr_in;
`ifdef ADDR_REG_ADDR_LOAD_EN
    logic             load_addr;
`endif
    logic             assert_addr;
    logic [WIDTH-1:0] addr_out;
    logic             addr_en;
    logic [WIDTH-1:0] xfer_in;
    logic             load_xfer;
    logic             assert_xfer;
    logic [WIDTH-1:0] xfer_out;
    logic             xfer_en;
    logic             inc;
    logic             dec;

    modport master (
        output addr_in,
`ifdef ADDR_REG_ADDR_LOAD_EN
        output load_addr,
`endif
        output assert_addr, xfer_in, load_xfer, assert_xfer, inc, dec,
        input  addr_out, addr_en, xfer_out, xfer_en
    );

    modport slave (
        input  addr_in,
`ifdef ADDR_REG_ADDR_LOAD_EN
        input  load_addr,
`endif
        input  assert_addr, xfer_in, load_xfer, assert_xfer, inc, dec,
        output addr_out, addr_en, xfer_out, xfer_en
    );

endinterface
`default_nettype wire

// File: rtl/addr_register_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter
// Description : Register with sync reset, parallel load and +/-1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    input  wire logic             i_inc,
    input  wire logic             i_dec,
    output logic      [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_value;

    // Natural modulo-2^WIDTH arithmetic provides the wrap in both directions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_value;
        end else if (i_inc) begin
            r_value <= r_value + c_one;
        end else if (i_dec) begin
            r_value <= r_value - c_one;
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/addr_register.sv
`default_nettype none
// ============================================================================
// Module      : addr_register
// Description : PC / address pointer on the address and xfer buses.
//               Macro ADDR_REG_ADDR_LOAD_EN enables loading from addr_in.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_register
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     reset,
    addr_register_if.slave bus
);

    logic             w_load;
    logic [WIDTH-1:0] w_load_value;
    logic             w_inc;
    logic             w_dec;
    logic [WIDTH-1:0] w_value;

    // xfer load outranks addr load
    always_comb begin
        w_load       = 1'b0;
        w_load_value = bus.xfer_in;
        if (bus.load_xfer == STROBE_ON) begin
            w_load       = 1'b1;
            w_load_value = bus.xfer_in;
        end
`ifdef ADDR_REG_ADDR_LOAD_EN
        else if (bus.load_addr == STROBE_ON) begin
            w_load       = 1'b1;
            w_load_value = bus.addr_in;
        end
`endif
    end

`ifndef ADDR_REG_ADDR_LOAD_EN
    logic w_addr_in_unused;
    assign w_addr_in_unused = ^bus.addr_in;
`endif

    // inc and dec strobed together cancel out
    assign w_inc = (bus.inc == STROBE_ON)  && (bus.dec == STROBE_OFF);
    assign w_dec = (bus.dec == STROBE_ON)  && (bus.inc == STROBE_OFF);

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_inc        (w_inc),
        .i_dec        (w_dec),
        .o_value      (w_value)
    );

    assign bus.addr_out = w_value;
    assign bus.xfer_out = w_value;
    assign bus.addr_en  = ~bus.assert_addr;
    assign bus.xfer_en  = ~bus.assert_xfer;

endmodule
`default_nettype wire

// File: tb/tb_addr_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_register
// Description : Directed and random checks of addr_register against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_register;
    import cpu_bus_pkg::*;

    localparam int W   = 16;
    localparam int MOD = 65536;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    addr_register_if #(.WIDTH(W)) bus ();

    addr_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int model  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_val(input int cur);
        if (reset) return 0;
        if (!bus.load_xfer) return int'(bus.xfer_in);
`ifdef ADDR_REG_ADDR_LOAD_EN
        if (!bus.load_addr) return int'(bus.addr_in);
`endif
        if (!bus.inc && bus.dec) return (cur + 1) % MOD;
        if (!bus.dec && bus.inc) return (cur + MOD - 1) % MOD;
        return cur;
    endfunction

    // Resolver with this register as the only source on each bus
    function automatic logic [W-1:0] addr_bus();
        return (!bus.assert_addr) ? bus.addr_out : ADDR_BUS_IDLE;
    endfunction
    function automatic logic [W-1:0] xfer_bus();
        return (!bus.assert_xfer) ? bus.xfer_out : ADDR_BUS_IDLE;
    endfunction

    task automatic tick();
        @(posedge clk);
        model = next_val(model);
        #1;
    endtask

    task automatic idle();
        reset         = 1'b0;
        bus.load_xfer = STROBE_OFF;
`ifdef ADDR_REG_ADDR_LOAD_EN
        bus.load_addr = STROBE_OFF;
`endif
        bus.inc       = STROBE_OFF;
        bus.dec       = STROBE_OFF;
    endtask

    task automatic load(input logic [W-1:0] v);
        bus.xfer_in   = v;
        bus.load_xfer = STROBE_ON;
        tick();
        bus.load_xfer = STROBE_OFF;
    endtask

    initial begin
        idle();
        reset           = 1'b1;
        bus.addr_in     = 16'hA5A5;
        bus.xfer_in     = 16'h0000;
        bus.assert_addr = STROBE_ON;
        bus.assert_xfer = STROBE_OFF;
        tick();
        reset = 1'b0;
        check("reset_addr_out", bus.addr_out, 32'h0000);
        check("reset_xfer_out", bus.xfer_out, 32'h0000);
        check("reset_addr_en", bus.addr_en, 32'h1);
        check("reset_xfer_en", bus.xfer_en, 32'h0);

        bus.assert_addr = STROBE_OFF;
        load(16'h5555);
        check("load_addr_bus_idle", addr_bus(), 32'hFFFF);
        bus.assert_addr = STROBE_ON;
        #1;
        check("load_addr_bus", addr_bus(), 32'h5555);
        check("load_model", bus.addr_out, 32'(model));

        bus.inc = STROBE_ON; tick(); bus.inc = STROBE_OFF;
        check("inc_5556", bus.addr_out, 32'h5556);
        bus.dec = STROBE_ON; tick(); bus.dec = STROBE_OFF;
        check("dec_5555", bus.addr_out, 32'h5555);
        bus.inc = STROBE_ON; bus.dec = STROBE_ON; tick(); idle();
        check("both_hold", bus.addr_out, 32'h5555);
        bus.inc = STROBE_ON; repeat (3) tick(); idle();
        check("inc_x3", bus.addr_out, 32'h5558);

        load(16'hFFFF);
        bus.inc = STROBE_ON; tick(); idle();
        check("wrap_up", bus.addr_out, 32'h0000);
        bus.dec = STROBE_ON; tick(); idle();
        check("wrap_down", bus.xfer_out, 32'hFFFF);

        // Drive the xfer bus from the register and reload from it
        load(16'h5555);
        bus.assert_xfer = STROBE_ON;
        bus.assert_addr = STROBE_OFF;
        #1;
        check("xfer_en_comb", bus.xfer_en, 32'h1);
        check("addr_en_comb", bus.addr_en, 32'h0);
        bus.xfer_in = xfer_bus();
        bus.load_xfer = STROBE_ON; tick(); idle();
        check("xfer_selfload", bus.xfer_out, 32'h5555);
        bus.assert_xfer = STROBE_OFF;
        #1;
        check("xfer_bus_idle", xfer_bus(), 32'hFFFF);

        bus.xfer_in = 16'h1234; bus.load_xfer = STROBE_ON; bus.inc = STROBE_ON;
        tick(); idle();
        check("prio_load_over_inc", bus.addr_out, 32'h1234);
        bus.xfer_in = 16'h4321; bus.load_xfer = STROBE_ON; reset = 1'b1;
        tick(); idle();
        check("prio_reset_over_load", bus.addr_out, 32'h0000);

`ifdef ADDR_REG_ADDR_LOAD_EN
        bus.addr_in = 16'hBEEF; bus.load_addr = STROBE_ON; bus.dec = STROBE_ON;
        tick(); idle();
        check("addr_load", bus.addr_out, 32'hBEEF);
`else
        bus.addr_in = 16'hBEEF; bus.dec = STROBE_ON;
        tick(); idle();
        check("addr_in_ignored", bus.addr_out, 32'hFFFF);
`endif

        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 31) == 0);
            bus.load_xfer = ($urandom_range(0, 7) != 0);
`ifdef ADDR_REG_ADDR_LOAD_EN
            bus.load_addr = ($urandom_range(0, 7) != 0);
            bus.addr_in   = W'($urandom);
`endif
            case ($urandom_range(0, 3))
                0:       bus.xfer_in = 16'hFFFF;
                1:       bus.xfer_in = 16'h0000;
                default: bus.xfer_in = W'($urandom);
            endcase
            bus.inc         = ($urandom_range(0, 2) != 0);
            bus.dec         = ($urandom_range(0, 2) != 0);
            bus.assert_addr = 1'($urandom);
            bus.assert_xfer = 1'($urandom);
            tick();
            check("rand_addr_out", bus.addr_out, 32'(model));
            check("rand_xfer_out", bus.xfer_out, 32'(model));
            check("rand_addr_en", bus.addr_en, 32'(!bus.assert_addr));
            check("rand_xfer_en", bus.xfer_en, 32'(!bus.assert_xfer));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
